cpu_checker_pro: RTL and testbench

CPU_CHECKER_PRO -- requirements
Module: cpu_checker_pro

---
 rtl/cpu_checker_pro.sv | 139 +++++++++++++
 tb/tb_cpu_checker_pro.sv | 96 +++++++++
 2 files changed

// File: rtl/cpu_checker_pro.sv
// cpu_checker_pro: streaming checker for "^T@P: $G <= D#" / "^T@P: *A <= D#" trace records
// Ports: clk, reset (sync, active-high); freq = clock period; char = one ASCII byte per cycle;
// format_type (0 none, 1 reg write, 2 mem write) and error_code pulse for one cycle after '#'.
module cpu_checker_pro #(
  parameter int          TIME_DIGITS_MAX = 4,
  parameter int          GRF_DIGITS_MAX  = 4,
  parameter int          GRF_NUM         = 32,
  parameter logic [31:0] PC_LO           = 32'h0000_3000,
  parameter logic [31:0] PC_HI           = 32'h0000_4ffc,
  parameter logic [31:0] ADDR_LO         = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI         = 32'h0000_2ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] freq,
  input  logic [7:0]  char,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code
);
  localparam logic [7:0]  TMAX = 8'(TIME_DIGITS_MAX);
  localparam logic [7:0]  GMAX = 8'(GRF_DIGITS_MAX);
  localparam logic [31:0] GNUM = 32'(GRF_NUM);
  typedef enum logic [3:0] {
    IDLE, TIME, PC, COLON, SP1, GRF, SP_G, LT, EQ, DATA, HASH, ADDR, SP_A
  } state_t;
  state_t      r_state;
  logic [31:0] r_t, r_p, r_a, r_g;
  logic [7:0]  r_cnt;
  logic        r_fmt2;
  logic        w_dec, w_hex, w_sp_lt, w_ok;
  logic [3:0]  w_hval;
  logic [31:0] w_half, w_half_nz, w_p_off, w_a_off;
  logic [3:0]  w_err;
  assign w_dec   = char >= "0" && char <= "9";
  assign w_hex   = w_dec || (char >= "a" && char <= "f");
  assign w_hval  = w_dec ? char[3:0] : char[3:0] + 4'd9;
  assign w_sp_lt = char == " " || char == "<";
  // Range checks as unsigned offsets so a zero lower bound needs no special case.
  assign w_half    = 32'(freq >> 1);
  assign w_half_nz = w_half == '0 ? 32'd1 : w_half;
  assign w_p_off   = r_p - PC_LO;
  assign w_a_off   = r_a - ADDR_LO;
  assign w_err[0]  = w_half == '0 || (r_t % w_half_nz) != '0;
  assign w_err[1]  = w_p_off > (PC_HI - PC_LO) || r_p[1:0] != 2'b00;
  assign w_err[2]  = r_fmt2 && (w_a_off > (ADDR_HI - ADDR_LO) || r_a[1:0] != 2'b00);
  assign w_err[3]  = !r_fmt2 && r_g >= GNUM;
  // Legality of char in the current state; anything illegal aborts the record.
  always_comb begin
    w_ok = 1'b0;
    case (r_state)
      IDLE:        w_ok = 1'b1;
      TIME:        w_ok = (w_dec && r_cnt < TMAX) || (char == "@" && r_cnt != '0);
      PC, DATA:    w_ok = w_hex;
      COLON:       w_ok = char == ":";
      SP1:         w_ok = char == " " || char == "$" || char == "*";
      GRF:         w_ok = (w_dec && r_cnt < GMAX) || (w_sp_lt && r_cnt != '0);
      SP_G, SP_A:  w_ok = w_sp_lt;
      ADDR:        w_ok = (w_hex && r_cnt < 8'd8) || (w_sp_lt && r_cnt == 8'd8);
      LT:          w_ok = char == "=";
      EQ:          w_ok = char == " " || w_hex;
      HASH:        w_ok = char == "#";
      default:     w_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset || char == "^" || !w_ok) begin
      r_state     <= (!reset && char == "^") ? TIME : IDLE;
      r_t         <= '0;
      r_p         <= '0;
      r_a         <= '0;
      r_g         <= '0;
      r_cnt       <= '0;
      r_fmt2      <= 1'b0;
      format_type <= '0;
      error_code  <= '0;
    end else begin
      format_type <= '0;
      error_code  <= '0;
      case (r_state)
        TIME: begin
          if (w_dec) begin
            r_t   <= r_t * 32'd10 + {28'b0, w_hval};
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_state <= PC;
            r_cnt   <= '0;
          end
        end
        PC: begin
          r_p     <= {r_p[27:0], w_hval};
          r_cnt   <= r_cnt + 8'd1;
          r_state <= r_cnt == 8'd7 ? COLON : PC;
        end
        COLON: r_state <= SP1;
        SP1: begin
          r_cnt   <= '0;
          r_fmt2  <= char == "*";
          r_state <= char == "$" ? GRF : char == "*" ? ADDR : SP1;
        end
        GRF: begin
          if (w_dec) begin
            r_g   <= r_g * 32'd10 + {28'b0, w_hval};
            r_cnt <= r_cnt + 8'd1;
          end else
            r_state <= char == "<" ? LT : SP_G;
        end
        ADDR: begin
          if (w_hex) begin
            r_a   <= {r_a[27:0], w_hval};
            r_cnt <= r_cnt + 8'd1;
          end else
            r_state <= char == "<" ? LT : SP_A;
        end
        SP_G, SP_A: r_state <= char == "<" ? LT : r_state;
        LT: r_state <= EQ;
        EQ: begin
          r_cnt   <= 8'd1;
          r_state <= w_hex ? DATA : EQ;
        end
        DATA: begin
          r_cnt   <= r_cnt + 8'd1;
          r_state <= r_cnt == 8'd7 ? HASH : DATA;
        end
        HASH: begin
          format_type <= r_fmt2 ? 2'd2 : 2'd1;
          error_code  <= w_err;
          r_state     <= IDLE;
          r_t         <= '0;
          r_p         <= '0;
          r_a         <= '0;
          r_g         <= '0;
          r_cnt       <= '0;
          r_fmt2      <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_checker_pro.sv
// tb_cpu_checker_pro: directed record streams with hand-computed pulse counts and flags
module tb_cpu_checker_pro;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] freq = 16'd2;
  logic [7:0]  char = 8'h00;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  int          total = 0;
  int          bad = 0;
  int          pulses;
  logic [1:0]  last_ft;
  logic [3:0]  last_ec;
  always #5 clk = ~clk;
  cpu_checker_pro dut (
    .clk(clk),
    .reset(reset),
    .freq(freq),
    .char(char),
    .format_type(format_type),
    .error_code(error_code)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(logic [7:0] c);
    char = c;
    @(posedge clk);
    #1;
    if (format_type != 2'd0) begin
      pulses++;
      last_ft = format_type;
      last_ec = error_code;
    end
  endtask
  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) tick(s[i]);
  endtask
  task automatic rec(string tag, string s, int np, logic [1:0] ft, logic [3:0] ec);
    pulses = 0;
    last_ft = 2'd0;
    last_ec = 4'd0;
    send(s);
    tick(8'h00);
    check({tag, ".n"}, pulses, np);
    check({tag, ".ft"}, {30'b0, last_ft}, {30'b0, ft});
    check({tag, ".ec"}, {28'b0, last_ec}, {28'b0, ec});
    check({tag, ".clr"}, {26'b0, format_type, error_code}, 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst", {26'b0, format_type, error_code}, 32'd0);
    reset = 1'b0;
    freq = 16'd2;
    rec("r026", "^10@00003010: $5 <= 0000000a#", 1, 2'd1, 4'b0000);
    freq = 16'd4;
    rec("r027", "^13@00002ffe: *00003000 <= 12345678#", 1, 2'd2, 4'b0111);
    freq = 16'd2;
    rec("r028", "^4@00003000: $32 <= ffffffff#", 1, 2'd1, 4'b1000);
    rec("t5dig", "^12345@00003000: $1 <= 00000000#", 0, 2'd0, 4'd0);
    rec("pcG", "^1@0000300G: $1 <= 00000000#", 0, 2'd0, 4'd0);
    rec("r030", "^1@00^2@00003000: $1 <= 00000000#", 1, 2'd1, 4'b0000);
    pulses = 0;
    send("^10@00003010: $5 <= 0000");
    reset = 1'b1;
    tick("0");
    check("midrst", {26'b0, format_type, error_code}, 32'd0);
    reset = 1'b0;
    send("0000#");
    tick(8'h00);
    check("midrst.n", pulses, 0);
    rec("after", "^10@00003010: $5 <= 0000000a#", 1, 2'd1, 4'b0000);
    rec("f2ok", "^8@00003ffc:*00002ffc<=deadbeef#", 1, 2'd2, 4'b0000);
    rec("max", "^9999@00004ffc: $0031 <= 01234567#", 1, 2'd1, 4'b0000);
    rec("g5dig", "^1@00003000: $00031 <= 00000000#", 0, 2'd0, 4'd0);
    rec("upper", "^2@00003000: $1 <= 0000000A#", 0, 2'd0, 4'd0);
    rec("pc7", "^2@0000300: $1 <= 00000000#", 0, 2'd0, 4'd0);
    rec("d9", "^2@00003000: $1 <= 000000000#", 0, 2'd0, 4'd0);
    freq = 16'd6;
    rec("tmod", "^10@00003000: $0 <= 00000000#", 1, 2'd1, 4'b0001);
    rec("phi", "^9@00005000: $0 <= 00000000#", 1, 2'd1, 4'b0010);
    freq = 16'd1;
    rec("f0", "^0@00003000: $0 <= 00000000#", 1, 2'd1, 4'b0001);
    freq = 16'd2;
    rec("amis", "^2@00003000: *00000002 <= 00000000#", 1, 2'd2, 4'b0100);
    rec("pmis", "^2@00003001: $1 <= 00000000#", 1, 2'd1, 4'b0010);
    rec("b2b", "^8@00003000: $40 <= 00000000#^7@00003004: *00000004 <= 00000000#", 2, 2'd2, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
